// File: rtl/crc_pkg.sv
// Shared CRC framing types and helpers.
// Used by the transmit appender and the receive-side checker.
package crc_pkg;

  typedef enum logic {PAYLOAD, APPEND} appender_state_t;

  // idx counts bytes in emission order; nbytes is the CRC width in bytes
  function automatic logic [7:0] crc_byte_sel(
    input logic [63:0] crc,
    input int unsigned idx,
    input bit          lsb_first,
    input int unsigned nbytes = 2
  );
    int unsigned sel;
    sel = lsb_first ? idx : nbytes - 1 - idx;
    return 8'(crc >> (8 * sel));
  endfunction

endpackage

// File: rtl/crc_frame_appender_crc_calc.sv
// Byte-wide parameterised CRC engine.
// Reflected variants reflect data in and result out around an MSB-first core.
module crc_calc #(
  parameter logic [63:0] POLY     = 64'h1021,
  parameter int          CRC_SIZE = 16,
  parameter logic [63:0] INIT     = 64'hffff,
  parameter bit          REF_IN   = 1'b1,
  parameter bit          REF_OUT  = 1'b1,
  parameter logic [63:0] XOR_OUT  = 64'h0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                soft_reset_i,
  input  logic                valid_i,
  input  logic [7:0]          data_i,
  output logic [CRC_SIZE-1:0] crc_o
);

  localparam int W = CRC_SIZE;
  localparam logic [W-1:0] P = POLY[W-1:0];
  localparam logic [W-1:0] I = INIT[W-1:0];
  localparam logic [W-1:0] X = XOR_OUT[W-1:0];

  logic [W-1:0] crc_q, crc_d;

  function automatic logic [W-1:0] step(
    input logic [W-1:0] c,
    input logic [7:0]   d
  );
    logic [7:0] b;
    logic       fb;
    b = REF_IN ? {<<{d}} : d;
    for (int i = 7; i >= 0; i--) begin
      fb = c[W-1] ^ b[i];
      c  = {c[W-2:0], 1'b0};
      if (fb) c = c ^ P;
    end
    return c;
  endfunction

  function automatic logic [W-1:0] xform(
    input logic [W-1:0] c
  );
    logic [W-1:0] r;
    r = REF_OUT ? {<<{c}} : c;
    return r ^ X;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (soft_reset_i)
      crc_d = I;
    else if (valid_i)
      crc_d = step(crc_q, data_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= I;
      crc_o <= xform(I);
    end else begin
      crc_q <= crc_d;
      crc_o <= xform(crc_d);
    end
  end

endmodule

// File: rtl/crc_frame_appender.sv
// Transmit framer: forwards payload bytes, then appends the frame CRC.
// One registered output stage with a valid/ready handshake on both sides.
module crc_frame_appender
  import crc_pkg::*;
#(
  parameter logic [63:0] POLY          = 64'h1021,
  parameter int          CRC_SIZE      = 16,
  parameter logic [63:0] INIT          = 64'hffff,
  parameter bit          REF_IN        = 1'b1,
  parameter bit          REF_OUT       = 1'b1,
  parameter logic [63:0] XOR_OUT       = 64'h0000,
  parameter bit          CRC_LSB_FIRST = 1'b1,
  parameter int          CNT_WIDTH     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [7:0]           s_data_i,
  input  logic                 s_last_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [7:0]           m_data_o,
  output logic                 m_last_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o
);

  localparam int NB = CRC_SIZE / 8;
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  if (CRC_SIZE % 8 != 0 || CRC_SIZE < 8 || CRC_SIZE > 64) begin : g_bad_size
    $error("CRC_SIZE must be a multiple of 8 in 8..64");
  end

  appender_state_t      state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                crc_valid;
  logic                crc_soft_rst;
  logic [CRC_SIZE-1:0] crc;
  logic                out_free;

  assign out_free = !valid_q || m_ready_i;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    s_ready_o    = 1'b0;
    crc_valid    = 1'b0;
    crc_soft_rst = 1'b0;
    unique case (state_q)
      PAYLOAD: begin
        s_ready_o = out_free;
        if (s_valid_i && out_free) begin
          data_d    = s_data_i;
          valid_d   = 1'b1;
          last_d    = 1'b0;
          crc_valid = 1'b1;
          if (s_last_i) begin
            state_d = APPEND;
            idx_d   = '0;
          end
        end else if (out_free) begin
          valid_d = 1'b0;
        end
      end
      APPEND: begin
        if (out_free) begin
          data_d  = crc_byte_sel(64'(crc), 32'(idx_q), CRC_LSB_FIRST, NB);
          valid_d = 1'b1;
          last_d  = (idx_q == LAST_IDX);
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            crc_soft_rst = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            state_d      = PAYLOAD;
            idx_d        = '0;
          end
        end
      end
      default: state_d = PAYLOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PAYLOAD;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  crc_calc #(
    .POLY     (POLY),
    .CRC_SIZE (CRC_SIZE),
    .INIT     (INIT),
    .REF_IN   (REF_IN),
    .REF_OUT  (REF_OUT),
    .XOR_OUT  (XOR_OUT)
  ) u_crc (
    .clk_i        (clk_i),
    .rst_i        (~rst_n_i),
    .soft_reset_i (crc_soft_rst),
    .valid_i      (crc_valid),
    .data_i       (s_data_i),
    .crc_o        (crc)
  );

  assign m_valid_o   = valid_q;
  assign m_data_o    = data_q;
  assign m_last_o    = last_q;
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_crc_frame_appender.sv
// Bench for crc_frame_appender: LSB-first and MSB-first instances in lockstep.
// Expected beats are queued per instance and popped as the outputs fire.
module tb_crc_frame_appender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_ready;

  logic        s_ready_a, m_valid_a, m_last_a;
  logic [7:0]  m_data_a;
  logic [31:0] cnt_a;
  logic        s_ready_b, m_valid_b, m_last_b;
  logic [7:0]  m_data_b;
  logic [31:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  bit rand_ready = 1'b0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data;

  crc_frame_appender dut_a (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready_a),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .m_valid_o   (m_valid_a),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data_a),
    .m_last_o    (m_last_a),
    .frame_cnt_o (cnt_a)
  );

  crc_frame_appender #(.CRC_LSB_FIRST(1'b0)) dut_b (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready_b),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .m_valid_o   (m_valid_b),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data_b),
    .m_last_o    (m_last_b),
    .frame_cnt_o (cnt_b)
  );

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst_n) begin
      if (stall_q) begin
        checks++;
        if (m_valid_a !== 1'b1 || m_data_a !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h required v=1 d=%h",
                   m_valid_a, m_data_a, stall_data);
        end
      end
      if (m_valid_a && m_ready) begin
        beats++;
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL beat_a: got %h with empty scoreboard", {m_last_a, m_data_a});
        end else begin
          exp = qa.pop_front();
          if ({m_last_a, m_data_a} !== exp) begin
            errors++;
            $display("FAIL beat_a: got last=%b data=%h required last=%b data=%h",
                     m_last_a, m_data_a, exp[8], exp[7:0]);
          end
        end
      end
      if (m_valid_b && m_ready) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL beat_b: got %h with empty scoreboard", {m_last_b, m_data_b});
        end else begin
          exp = qb.pop_front();
          if ({m_last_b, m_data_b} !== exp) begin
            errors++;
            $display("FAIL beat_b: got last=%b data=%h required last=%b data=%h",
                     m_last_b, m_data_b, exp[8], exp[7:0]);
          end
        end
      end
      stall_q    = m_valid_a && !m_ready;
      stall_data = m_data_a;
    end else begin
      stall_q = 1'b0;
    end
  end

  // CRC-16/MCRF4XX, right-shifting reflected form
  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] c;
    c = 16'hffff;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_payload(input logic [7:0] d[$]);
    foreach (d[i]) begin
      qa.push_back({1'b0, d[i]});
      qb.push_back({1'b0, d[i]});
    end
  endtask

  task automatic push_crc(input logic [15:0] c);
    qa.push_back({1'b0, c[7:0]});
    qa.push_back({1'b1, c[15:8]});
    qb.push_back({1'b0, c[15:8]});
    qb.push_back({1'b1, c[7:0]});
  endtask

  task automatic send_bytes(input logic [7:0] d[$], input bit last);
    int  n;
    bit  acc;
    foreach (d[i]) begin
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = last && (i == d.size() - 1);
      n = 0;
      do begin
        @(negedge clk);
        acc = s_ready_a;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 200);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %h not accepted, required accept", d[i]);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d[$], input logic [15:0] c);
    push_payload(d);
    push_crc(c);
    send_bytes(d, 1'b1);
  endtask

  task automatic drain_and_count(input int exp_cnt);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d beats pending, required 0", qa.size(), qb.size());
    end
    checks++;
    if (cnt_a !== 32'(exp_cnt) || cnt_b !== 32'(exp_cnt)) begin
      errors++;
      $display("FAIL frame_cnt: got %0d/%0d required %0d", cnt_a, cnt_b, exp_cnt);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] f1[$];

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid_a !== 1'b0 || m_data_a !== 8'h00 || m_last_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h l=%b required 0 00 0",
               m_valid_a, m_data_a, m_last_a);
    end
    checks++;
    if (cnt_a !== 32'd0 || cnt_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d required 0", cnt_a, cnt_b);
    end
    checks++;
    if (s_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", s_ready_a);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(f1, 16'h6f91);
    drain_and_count(1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(f1, 16'h6f91);
    send_frame(f1, 16'h6f91);
    drain_and_count(2);
  endtask

  task automatic test_backpressure();
    do_reset();
    rand_ready = 1'b1;
    send_frame(f1, 16'h6f91);
    drain_and_count(1);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [7:0] part[$];
    do_reset();
    part = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    push_payload(part);
    send_bytes(part, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid_a !== 1'b0 || m_data_a !== 8'h00 || m_last_a !== 1'b0 ||
        m_valid_b !== 1'b0 || m_data_b !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h l=%b required 0 00 0",
               m_valid_a, m_data_a, m_last_a);
    end
    do_reset();
    send_frame(f1, 16'h6f91);
    drain_and_count(1);
  endtask

  task automatic test_single_byte();
    logic [7:0] one[$];
    int b0;
    do_reset();
    one = '{8'h00};
    b0 = beats;
    push_payload(one);
    push_crc(crc_ref(one));
    send_bytes(one, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (s_ready_a !== (k == 2)) begin
        errors++;
        $display("FAIL single_ready[%0d]: got %b required %b", k, s_ready_a, k == 2);
      end
    end
    drain_and_count(1);
    checks++;
    if (beats - b0 != 3) begin
      errors++;
      $display("FAIL single_beats: got %0d required 3", beats - b0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    m_ready = 1'b1;
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_single_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
